// File: rtl/button_debounce.sv
// Pushbutton conditioner: brings the raw button pin into the int_osc domain
// through a two-flop synchronizer, then rejects contact bounce. It reports
// debounced press/release strobes, a long-press strobe, a long-held flag and a
// wrapping 8-bit press counter. Every output comes straight from a flop.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int LONG_CYCLES     = 48000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       int_osc,
    input  logic       rstn,
    input  logic       BTN0,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       long_held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'b00,
        ST_PRESS_WAIT   = 2'b01,
        ST_PRESSED      = 2'b10,
        ST_RELEASE_WAIT = 2'b11
    } state_t;

    // Pin level that means "not pressed"; the synchronizer resets to it so a
    // reset never looks like a press edge.
    localparam logic        SYNC_IDLE = ACTIVE_LOW;
    localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE_CYCLES - 1);
    localparam bit          DB_SINGLE = (DEBOUNCE_CYCLES == 1);
    localparam logic [27:0] LONG_LAST = 28'(LONG_CYCLES - 1);
    localparam logic [27:0] LONG_SAT  = 28'(LONG_CYCLES);

    logic        sync1_r, sync2_r;
    logic        pressed_s;
    state_t      state_r, state_nx_s;
    logic [23:0] db_cnt_r, db_cnt_nx_s;
    logic [27:0] hold_cnt_r, hold_cnt_nx_s;
    logic        level_r, level_nx_s;
    logic        press_r, press_nx_s;
    logic        release_r, release_nx_s;
    logic        long_r, long_nx_s;
    logic        held_r, held_nx_s;
    logic [7:0]  count_r, count_nx_s;

    // Two-flop synchronizer on the asynchronous button pin.
    always_ff @(posedge int_osc or negedge rstn) begin
        if (!rstn) begin
            sync1_r <= SYNC_IDLE;
            sync2_r <= SYNC_IDLE;
        end else begin
            sync1_r <= BTN0;
            sync2_r <= sync1_r;
        end
    end

    // Polarity is applied only after the second flop.
    assign pressed_s = ACTIVE_LOW ? ~sync2_r : sync2_r;

    // Next-state and next-output logic for the debounce FSM and hold timer.
    always_comb begin
        state_nx_s    = state_r;
        db_cnt_nx_s   = db_cnt_r;
        hold_cnt_nx_s = hold_cnt_r;
        level_nx_s    = level_r;
        press_nx_s    = 1'b0;
        release_nx_s  = 1'b0;
        long_nx_s     = 1'b0;
        held_nx_s     = held_r;
        count_nx_s    = count_r;

        // Hold timer runs while the debounced level is high, including during
        // a pending release, and saturates so the long strobe fires once.
        if ((state_r == ST_PRESSED) || (state_r == ST_RELEASE_WAIT)) begin
            if (hold_cnt_r < LONG_SAT) begin
                hold_cnt_nx_s = hold_cnt_r + 28'd1;
                if (hold_cnt_r == LONG_LAST) begin
                    long_nx_s = 1'b1;
                    held_nx_s = 1'b1;
                end else begin
                    long_nx_s = 1'b0;
                end
            end else begin
                hold_cnt_nx_s = hold_cnt_r;
            end
        end else begin
            hold_cnt_nx_s = hold_cnt_r;
        end

        case (state_r)
            ST_RELEASED: begin
                if (pressed_s) begin
                    db_cnt_nx_s = 24'd1;
                    if (DB_SINGLE) begin
                        state_nx_s    = ST_PRESSED;
                        press_nx_s    = 1'b1;
                        level_nx_s    = 1'b1;
                        count_nx_s    = count_r + 8'd1;
                        hold_cnt_nx_s = 28'd0;
                        held_nx_s     = 1'b0;
                    end else begin
                        state_nx_s = ST_PRESS_WAIT;
                    end
                end else begin
                    state_nx_s = ST_RELEASED;
                end
            end
            ST_PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_nx_s = ST_RELEASED;
                end else if (db_cnt_r == DB_LAST) begin
                    state_nx_s    = ST_PRESSED;
                    press_nx_s    = 1'b1;
                    level_nx_s    = 1'b1;
                    count_nx_s    = count_r + 8'd1;
                    hold_cnt_nx_s = 28'd0;
                    held_nx_s     = 1'b0;
                end else begin
                    db_cnt_nx_s = db_cnt_r + 24'd1;
                end
            end
            ST_PRESSED: begin
                if (!pressed_s) begin
                    db_cnt_nx_s = 24'd1;
                    if (DB_SINGLE) begin
                        state_nx_s   = ST_RELEASED;
                        release_nx_s = 1'b1;
                        level_nx_s   = 1'b0;
                        held_nx_s    = 1'b0;
                    end else begin
                        state_nx_s = ST_RELEASE_WAIT;
                    end
                end else begin
                    state_nx_s = ST_PRESSED;
                end
            end
            ST_RELEASE_WAIT: begin
                if (pressed_s) begin
                    // Bounce during release: keep the accumulated hold time.
                    state_nx_s = ST_PRESSED;
                end else if (db_cnt_r == DB_LAST) begin
                    // Release wins over a coincident long strobe for long_held.
                    state_nx_s   = ST_RELEASED;
                    release_nx_s = 1'b1;
                    level_nx_s   = 1'b0;
                    held_nx_s    = 1'b0;
                end else begin
                    db_cnt_nx_s = db_cnt_r + 24'd1;
                end
            end
            default: begin
                state_nx_s    = ST_RELEASED;
                db_cnt_nx_s   = 24'd0;
                hold_cnt_nx_s = 28'd0;
                level_nx_s    = 1'b0;
                long_nx_s     = 1'b0;
                held_nx_s     = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge int_osc or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_RELEASED;
            db_cnt_r   <= 24'd0;
            hold_cnt_r <= 28'd0;
            level_r    <= 1'b0;
            press_r    <= 1'b0;
            release_r  <= 1'b0;
            long_r     <= 1'b0;
            held_r     <= 1'b0;
            count_r    <= 8'd0;
        end else begin
            state_r    <= state_nx_s;
            db_cnt_r   <= db_cnt_nx_s;
            hold_cnt_r <= hold_cnt_nx_s;
            level_r    <= level_nx_s;
            press_r    <= press_nx_s;
            release_r  <= release_nx_s;
            long_r     <= long_nx_s;
            held_r     <= held_nx_s;
            count_r    <= count_nx_s;
        end
    end

    assign btn_level     = level_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign long_pulse    = long_r;
    assign long_held     = held_r;
    assign press_count   = count_r;

endmodule

// File: tb/tb_button_debounce.sv
// Testbench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
// active-low button. The reference model treats the design as: a two-sample
// delay, then the debounced level flips once the most recent D delayed
// samples all disagree with it. The long strobe fires exactly L edges after
// the accepted press while the level was still high going into that edge.
module tb_button_debounce;

    localparam int D = 4;
    localparam int L = 20;

    logic       int_osc = 1'b0;
    logic       rstn    = 1'b0;
    logic       BTN0    = 1'b1;
    logic       btn_level, press_pulse, release_pulse, long_pulse, long_held;
    logic [7:0] press_count;

    button_debounce #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .int_osc      (int_osc),
        .rstn         (rstn),
        .BTN0         (BTN0),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .long_held    (long_held),
        .press_count  (press_count)
    );

    // Free-running clock.
    always #5 int_osc = ~int_osc;

    int checks = 0;
    int errors = 0;

    // Observed strobe totals, used by the scenario checks.
    int n_press, n_release, n_long;

    // Reference model state.
    bit         m_level, m_press, m_release, m_long, m_held;
    logic [7:0] m_count;
    int         m_edge, m_press_edge;
    bit         dq[$];
    bit         win[$];

    typedef struct {
        logic       btn;
        logic       level;
        logic       press;
        logic [7:0] count;
    } vec_t;
    vec_t tbl[8];

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 1'b0; m_press = 1'b0; m_release = 1'b0;
        m_long = 1'b0; m_held = 1'b0; m_count = 8'd0;
        m_edge = 0; m_press_edge = -100000;
        dq.delete(); dq.push_back(1'b0); dq.push_back(1'b0);
        win.delete();
    endtask

    // Advance the model by one clock edge with the pin value sampled there.
    task automatic model_edge(input logic btn);
        bit seen, prev, flip;
        seen = dq.pop_front();
        dq.push_back(bit'(~btn));
        win.push_back(seen);
        if (win.size() > D) void'(win.pop_front());
        prev = m_level;
        flip = (win.size() == D);
        foreach (win[i]) if (win[i] == prev) flip = 1'b0;
        m_edge++;
        m_press   = flip && !prev;
        m_release = flip && prev;
        if (flip) m_level = ~m_level;
        if (m_press) begin
            m_press_edge = m_edge;
            m_count = m_count + 8'd1;
        end
        m_long = prev && ((m_edge - m_press_edge) == L);
        m_held = m_level && ((m_edge - m_press_edge) >= L);
    endtask

    task automatic compare_all();
        check1("btn_level", btn_level, m_level);
        check1("press_pulse", press_pulse, m_press);
        check1("release_pulse", release_pulse, m_release);
        check1("long_pulse", long_pulse, m_long);
        check1("long_held", long_held, m_held);
        check8("press_count", press_count, m_count);
    endtask

    // Drive the pin at a falling edge, let one rising edge happen, then
    // compare at the next falling edge.
    task automatic step(input logic v);
        BTN0 = v;
        @(posedge int_osc);
        model_edge(v);
        @(negedge int_osc);
        compare_all();
        if (press_pulse) n_press++;
        if (release_pulse) n_release++;
        if (long_pulse) n_long++;
    endtask

    task automatic clear_counts();
        n_press = 0; n_release = 0; n_long = 0;
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #5000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int long_at, press_at;
        logic [7:0] prev_cnt;
        bit wrapped;

        // Clean press from reset: pin goes low just before edge 1.
        for (int i = 0; i < 8; i++) begin
            tbl[i].btn   = 1'b0;
            tbl[i].level = (i >= 5);
            tbl[i].press = (i == 5);
            tbl[i].count = (i >= 5) ? 8'd1 : 8'd0;
        end

        model_reset();
        clear_counts();
        repeat (3) @(negedge int_osc);
        check1("reset_level", btn_level, 1'b0);
        check1("reset_press", press_pulse, 1'b0);
        check1("reset_long_held", long_held, 1'b0);
        check8("reset_count", press_count, 8'd0);
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].btn);
            check1("tbl_level", btn_level, tbl[i].level);
            check1("tbl_press", press_pulse, tbl[i].press);
            check8("tbl_count", press_count, tbl[i].count);
        end
        clear_counts();
        for (int i = 1; i <= 10; i++) begin
            step(1'b1);
            if (i == 6) check1("clean_release_edge", release_pulse, 1'b1);
        end
        check_int("clean_release_once", n_release, 1);

        // Bounce rejection.
        clear_counts();
        repeat (5) begin
            repeat (3) step(1'b0);
            repeat (2) step(1'b1);
        end
        repeat (8) step(1'b1);
        check_int("bounce_no_press", n_press, 0);
        check1("bounce_level", btn_level, 1'b0);
        check8("bounce_count", press_count, 8'd1);

        // Long press, then release clears long_held on the release edge.
        clear_counts();
        repeat (6) step(1'b0);
        check1("long_press_edge", press_pulse, 1'b1);
        long_at = -1;
        for (int j = 1; j <= 40; j++) begin
            step(1'b0);
            if (long_pulse && long_at < 0) long_at = j;
        end
        check_int("long_at", long_at, L);
        check_int("long_once", n_long, 1);
        check1("long_held_set", long_held, 1'b1);
        repeat (5) step(1'b1);
        step(1'b1);
        check1("long_release_pulse", release_pulse, 1'b1);
        check1("long_release_held", long_held, 1'b0);

        // Release bounce keeps the level and the long timing.
        clear_counts();
        repeat (6) step(1'b0);
        long_at = -1;
        for (int j = 1; j <= 25; j++) begin
            step((j == 6 || j == 7) ? 1'b1 : 1'b0);
            if (long_pulse && long_at < 0) long_at = j;
        end
        check_int("rbounce_no_release", n_release, 0);
        check1("rbounce_level", btn_level, 1'b1);
        check_int("rbounce_long_at", long_at, L);
        repeat (6) step(1'b1);

        // Release accepted on the same edge as the long strobe.
        clear_counts();
        repeat (6) step(1'b0);
        for (int j = 1; j <= 20; j++) step((j >= 15) ? 1'b1 : 1'b0);
        check1("coinc_long", long_pulse, 1'b1);
        check1("coinc_release", release_pulse, 1'b1);
        check1("coinc_held", long_held, 1'b0);
        repeat (3) step(1'b1);

        // 256 clean presses: counter must pass 255 -> 0 and end where it began.
        clear_counts();
        wrapped = 1'b0;
        for (int k = 0; k < 256; k++) begin
            prev_cnt = press_count;
            repeat (6) step(1'b0);
            if (prev_cnt == 8'd255 && press_count == 8'd0) wrapped = 1'b1;
            repeat (6) step(1'b1);
        end
        check_int("wrap_seen", int'(wrapped), 1);
        check_int("wrap_presses", n_press, 256);
        check8("wrap_final", press_count, 8'd4);

        // Reset while the button is held.
        repeat (8) step(1'b0);
        #2 rstn = 1'b0;
        #1;
        check1("rst_mid_level", btn_level, 1'b0);
        check1("rst_mid_release", release_pulse, 1'b0);
        check1("rst_mid_long_held", long_held, 1'b0);
        check1("rst_mid_long", long_pulse, 1'b0);
        check1("rst_mid_press", press_pulse, 1'b0);
        check8("rst_mid_count", press_count, 8'd0);
        model_reset();
        @(negedge int_osc);
        rstn = 1'b1;
        clear_counts();
        press_at = -1;
        for (int i = 1; i <= 8; i++) begin
            step(1'b0);
            if (press_pulse && press_at < 0) press_at = i;
        end
        check_int("rst_repress_at", press_at, D + 2);
        check_int("rst_no_release", n_release, 0);
        repeat (6) step(1'b1);

        // Random runs against the model.
        for (int r = 0; r < 1500; r++) begin
            logic v;
            int len;
            v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) len = $urandom_range(20, 40);
            else len = $urandom_range(1, 7);
            repeat (len) step(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
